aes_block_serializer: RTL and testbench

Splits 128-bit AES blocks into a stream of 32-bit words on an HWPE stream source. It sits on the feeding side of the AES engine's 32-bit input stream and produces the words that the engine's sink port consumes. A control handshake sets how many blocks form one job. A sustained input delivers one word per cycle with no bubbles between blocks.

---
 rtl/aes_block_serializer_if.sv | 21 ++
 rtl/aes_block_serializer.sv | 180 ++++++++++++++++++
 tb/tb_aes_block_serializer.sv | 389 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_block_serializer_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | hwpe_stream_intf_stream : valid/ready word stream with byte strobes |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface hwpe_stream_intf_stream #(
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] data;
  logic [STRB_WIDTH-1:0] strb;
  logic                  valid;
  logic                  ready;

  modport source (output data, output strb, output valid, input  ready);
  modport sink   (input  data, input  strb, input  valid, output ready);
  modport master (output data, output strb, output valid, input  ready);
  modport slave  (input  data, input  strb, input  valid, output ready);
endinterface
`default_nettype wire

// File: rtl/aes_block_serializer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | aes_block_serializer : 128-bit blocks -> 32-bit word stream         |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module aes_block_serializer #(
  parameter int unsigned WORD_ORDER = 0,
  parameter int unsigned BYTE_SWAP  = 0,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   clear_i,
  input  logic                   start_i,
  input  logic [CNT_W-1:0]       nb_blocks_i,
  input  logic                   blk_valid_i,
  output logic                   blk_ready_o,
  input  logic [127:0]           blk_data_i,
  hwpe_stream_intf_stream.source words_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [CNT_W-1:0]       blk_cnt_o
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_BLK = 2'd1,
    SEND     = 2'd2,
    DONE     = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   nb_q, nb_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         idx_q, idx_d;
  logic [127:0]       hold_q, hold_d;
  logic               valid_q, valid_d;
  logic [31:0]        data_q, data_d;
  logic [3:0]         strb_q, strb_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [CNT_W-1:0]   cnt_inc;
  logic               word_hs;
  logic               last_word_hs;
  logic               more_blocks;
  logic               blk_hs;

  // Word idx counts output order; the reversed order picks from the top slice.
  function automatic logic [31:0] sel_word(input logic [127:0] blk, input logic [1:0] idx);
    logic [1:0]  pos;
    logic [31:0] w;
    pos = (WORD_ORDER != 0) ? ~idx : idx;
    w   = blk[{pos, 5'b00000} +: 32];
    if (BYTE_SWAP != 0) begin
      w = {w[7:0], w[15:8], w[23:16], w[31:24]};
    end
    return w;
  endfunction

  assign cnt_inc      = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
  assign word_hs      = valid_q & words_o.ready;
  assign last_word_hs = (state_q == SEND) & word_hs & (idx_q == 2'd3);
  assign more_blocks  = (cnt_inc != nb_q);
  assign blk_ready_o  = (state_q == WAIT_BLK) | (last_word_hs & more_blocks);
  assign blk_hs       = blk_valid_i & blk_ready_o;

  always_comb begin
    state_d = state_q;
    nb_d    = nb_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
    valid_d = valid_q;
    data_d  = data_q;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          cnt_d = '0;
          if (nb_blocks_i != '0) begin
            nb_d    = nb_blocks_i;
            state_d = WAIT_BLK;
          end else begin
            state_d = DONE;
          end
        end
      end
      WAIT_BLK: begin
        if (blk_hs) begin
          hold_d  = blk_data_i;
          idx_d   = 2'd0;
          data_d  = sel_word(blk_data_i, 2'd0);
          valid_d = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        if (word_hs) begin
          if (idx_q != 2'd3) begin
            idx_d  = idx_q + 2'd1;
            data_d = sel_word(hold_q, idx_q + 2'd1);
          end else begin
            cnt_d = cnt_inc;
            if (!more_blocks) begin
              valid_d = 1'b0;
              state_d = DONE;
            end else if (blk_hs) begin
              // Reload in the same cycle keeps the stream gap-free across blocks.
              hold_d = blk_data_i;
              idx_d  = 2'd0;
              data_d = sel_word(blk_data_i, 2'd0);
            end else begin
              valid_d = 1'b0;
              state_d = WAIT_BLK;
            end
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
    strb_d = valid_d ? 4'hF : 4'h0;

    if (clear_i) begin
      state_d = IDLE;
      nb_d    = '0;
      cnt_d   = '0;
      idx_d   = 2'd0;
      hold_d  = '0;
      valid_d = 1'b0;
      data_d  = '0;
      strb_d  = 4'h0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      nb_q    <= '0;
      cnt_q   <= '0;
      idx_q   <= 2'd0;
      hold_q  <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      strb_q  <= 4'h0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      nb_q    <= nb_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      strb_q  <= strb_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign words_o.valid = valid_q;
  assign words_o.data  = data_q;
  assign words_o.strb  = strb_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign blk_cnt_o     = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_aes_block_serializer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_aes_block_serializer : vectors, corner sequences, random jobs    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_aes_block_serializer;

  logic         clk = 1'b0;
  logic         rst, clear, start, blk_valid, ready;
  logic [15:0]  nb;
  logic [127:0] blk_data;

  always #5 clk = ~clk;

  hwpe_stream_intf_stream #(.DATA_WIDTH(32)) ifa ();
  hwpe_stream_intf_stream #(.DATA_WIDTH(32)) ifb ();
  hwpe_stream_intf_stream #(.DATA_WIDTH(32)) ifs ();
  assign ifa.ready = ready;
  assign ifb.ready = ready;
  assign ifs.ready = ready;

  logic        rdy_a, busy_a, done_a;
  logic        rdy_b, busy_b, done_b;
  logic        rdy_s, busy_s, done_s;
  logic [15:0] cnt_a, cnt_b;
  logic [1:0]  cnt_s;

  aes_block_serializer #(.WORD_ORDER(0), .BYTE_SWAP(0), .CNT_W(16)) dut_a (
    .clk_i(clk), .rst_i(rst), .clear_i(clear), .start_i(start), .nb_blocks_i(nb),
    .blk_valid_i(blk_valid), .blk_ready_o(rdy_a), .blk_data_i(blk_data), .words_o(ifa),
    .busy_o(busy_a), .done_o(done_a), .blk_cnt_o(cnt_a));

  aes_block_serializer #(.WORD_ORDER(1), .BYTE_SWAP(1), .CNT_W(16)) dut_b (
    .clk_i(clk), .rst_i(rst), .clear_i(clear), .start_i(start), .nb_blocks_i(nb),
    .blk_valid_i(blk_valid), .blk_ready_o(rdy_b), .blk_data_i(blk_data), .words_o(ifb),
    .busy_o(busy_b), .done_o(done_b), .blk_cnt_o(cnt_b));

  // Narrow counter instance: a 3-block job is the largest legal count for it.
  aes_block_serializer #(.WORD_ORDER(0), .BYTE_SWAP(0), .CNT_W(2)) dut_s (
    .clk_i(clk), .rst_i(rst), .clear_i(clear), .start_i(start), .nb_blocks_i(nb[1:0]),
    .blk_valid_i(blk_valid), .blk_ready_o(rdy_s), .blk_data_i(blk_data), .words_o(ifs),
    .busy_o(busy_s), .done_o(done_s), .blk_cnt_o(cnt_s));

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] word_of(input logic [127:0] blk, input int i,
                                          input bit order, input bit swap);
    logic [127:0] sh;
    logic [31:0]  w;
    sh = blk >> (32 * (order ? (3 - i) : i));
    w  = sh[31:0];
    if (swap) w = {w[7:0], w[15:8], w[23:16], w[31:24]};
    return w;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Reference model: job phase plus queues of words still owed to the stream.
  logic [31:0] qa[$];
  logic [31:0] qb[$];
  int          m_phase;   // 0 idle, 1 running, 2 done pulse
  int          m_nb, m_acc, m_words, m_cnt;
  bit          blk_hs_last = 1'b0;
  bit          check_s     = 1'b0;
  logic        exp_rdy;

  task automatic model_reset();
    qa.delete();
    qb.delete();
    m_phase = 0;
    m_nb    = 0;
    m_acc   = 0;
    m_words = 0;
    m_cnt   = 0;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      model_reset();
      blk_hs_last = 1'b0;
    end else begin
      exp_rdy = (m_phase == 1) && (m_acc < m_nb) &&
                ((qa.size() == 0) || (qa.size() == 1 && ready));
      chk("mon_valid_a", ifa.valid, qa.size() != 0);
      chk("mon_valid_b", ifb.valid, qb.size() != 0);
      if (qa.size() != 0) begin
        chk("mon_data_a", ifa.data, qa[0]);
        chk("mon_strb_a", ifa.strb, 4'hF);
        chk("mon_data_b", ifb.data, qb[0]);
      end
      chk("mon_busy_a", busy_a, m_phase != 0);
      chk("mon_done_a", done_a, m_phase == 2);
      chk("mon_cnt_a",  cnt_a,  m_cnt[15:0]);
      chk("mon_rdy_a",  rdy_a,  exp_rdy);
      chk("mon_rdy_b",  rdy_b,  exp_rdy);
      if (check_s) begin
        chk("mon_valid_s", ifs.valid, qa.size() != 0);
        if (qa.size() != 0) chk("mon_data_s", ifs.data, qa[0]);
        chk("mon_done_s", done_s, m_phase == 2);
        chk("mon_busy_s", busy_s, m_phase != 0);
        chk("mon_cnt_s",  cnt_s,  m_cnt[1:0]);
        chk("mon_rdy_s",  rdy_s,  exp_rdy);
      end

      blk_hs_last = blk_valid && exp_rdy && !clear;
      if (clear) begin
        model_reset();
      end else begin
        case (m_phase)
          0: begin
            if (start) begin
              m_cnt = 0;
              if (nb == 16'd0) begin
                m_phase = 2;
              end else begin
                m_phase = 1;
                m_nb    = int'(nb);
                m_acc   = 0;
                m_words = 0;
              end
            end
          end
          1: begin
            if (qa.size() != 0 && ready) begin
              void'(qa.pop_front());
              void'(qb.pop_front());
              m_words++;
              if (m_words % 4 == 0) begin
                m_cnt++;
                if (m_cnt == m_nb) m_phase = 2;
              end
            end
            if (blk_hs_last) begin
              for (int i = 0; i < 4; i++) begin
                qa.push_back(word_of(blk_data, i, 1'b0, 1'b0));
                qb.push_back(word_of(blk_data, i, 1'b1, 1'b1));
              end
              m_acc++;
            end
          end
          default: m_phase = 0;
        endcase
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, ifa.valid, 1'b0);
    chk({tag, "_data"},  ifa.data,  32'h0);
    chk({tag, "_strb"},  ifa.strb,  4'h0);
    chk({tag, "_busy"},  busy_a,    1'b0);
    chk({tag, "_done"},  done_a,    1'b0);
    chk({tag, "_cnt"},   cnt_a,     16'h0);
    chk({tag, "_rdy"},   rdy_a,     1'b0);
    chk({tag, "_valid_b"}, ifb.valid, 1'b0);
  endtask

  task automatic wait_done(input int budget, input string name);
    bit got;
    got = 1'b0;
    for (int c = 0; c < budget; c++) begin
      if (done_a) begin
        got = 1'b1;
        break;
      end
      step();
    end
    chk(name, got, 1'b1);
  endtask

  task automatic run_job(input int nbk, input string name);
    bit got;
    got   = 1'b0;
    nb    = nbk[15:0];
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if (done_a) begin
        got = 1'b1;
        break;
      end
      if (blk_valid && blk_hs_last) blk_valid = 1'b0;
      if (!blk_valid && $urandom_range(99) < 70) begin
        blk_valid = 1'b1;
        blk_data  = rnd128();
      end
      ready = ($urandom_range(99) < 75);
      // Stray starts while a job runs must be ignored.
      if ($urandom_range(29) == 0) begin
        start = 1'b1;
        nb    = 16'($urandom_range(0, 7));
      end else begin
        start = 1'b0;
      end
      step();
    end
    start = 1'b0;
    chk(name, got, 1'b1);
    blk_valid = 1'b0;
    ready     = 1'b1;
    step();
  endtask

  typedef struct {
    logic [127:0]       blk;
    logic [0:3][31:0]   ea;
    logic [0:3][31:0]   eb;
  } vec_t;

  vec_t tv[3];
  int   sent;
  logic [31:0] held;

  initial begin
    tv[0].blk = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    tv[0].ea  = {32'hCCDDEEFF, 32'h8899AABB, 32'h44556677, 32'h00112233};
    tv[0].eb  = {32'h33221100, 32'h77665544, 32'hBBAA9988, 32'hFFEEDDCC};
    tv[1].blk = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
    tv[1].ea  = {32'h76543210, 32'hFEDCBA98, 32'h89ABCDEF, 32'h01234567};
    tv[1].eb  = {32'h67452301, 32'hEFCDAB89, 32'h98BADCFE, 32'h10325476};
    tv[2].blk = 128'hDEADBEEF_00000001_80000000_CAFEF00D;
    tv[2].ea  = {32'hCAFEF00D, 32'h80000000, 32'h00000001, 32'hDEADBEEF};
    tv[2].eb  = {32'hEFBEADDE, 32'h01000000, 32'h00000080, 32'h0DF0FECA};

    rst = 1'b1; clear = 1'b0; start = 1'b0; blk_valid = 1'b0; ready = 1'b1;
    nb = 16'd0; blk_data = '0;
    step();
    step();
    chk_idle("reset");
    rst = 1'b0;
    step();

    // Single-block vectors: exact word order and cycle timing.
    for (int v = 0; v < 3; v++) begin
      nb    = 16'd1;
      start = 1'b1;
      step();
      start = 1'b0;
      chk("tbl_busy_after_start", busy_a, 1'b1);
      chk("tbl_rdy_after_start",  rdy_a,  1'b1);
      blk_valid = 1'b1;
      blk_data  = tv[v].blk;
      step();
      blk_valid = 1'b0;
      for (int w = 0; w < 4; w++) begin
        chk("tbl_valid",  ifa.valid, 1'b1);
        chk("tbl_word_a", ifa.data,  tv[v].ea[w]);
        chk("tbl_word_b", ifb.data,  tv[v].eb[w]);
        step();
      end
      chk("tbl_done", done_a, 1'b1);
      chk("tbl_cnt",  cnt_a,  16'd1);
      step();
      chk("tbl_busy_end", busy_a, 1'b0);
      chk("tbl_done_end", done_a, 1'b0);
    end

    // Back-to-back three blocks, also the maximum count of the 2-bit instance.
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk_idle("clear_idle");
    check_s   = 1'b1;
    nb        = 16'd3;
    start     = 1'b1;
    step();
    start     = 1'b0;
    blk_valid = 1'b1;
    blk_data  = rnd128();
    sent      = 0;
    step();
    if (blk_hs_last) begin sent++; blk_data = rnd128(); end
    for (int w = 0; w < 12; w++) begin
      chk("b2b_no_bubble", ifa.valid, 1'b1);
      step();
      if (blk_hs_last) begin
        sent++;
        if (sent < 3) blk_data = rnd128();
        else blk_valid = 1'b0;
      end
    end
    blk_valid = 1'b0;
    chk("b2b_done",   done_a, 1'b1);
    chk("b2b_cnt",    cnt_a,  16'd3);
    chk("b2b_done_s", done_s, 1'b1);
    chk("b2b_cnt_s",  cnt_s,  2'd3);
    step();
    check_s = 1'b0;

    // Backpressure on word1.
    nb = 16'd1; start = 1'b1;
    step();
    start = 1'b0; blk_valid = 1'b1; blk_data = rnd128();
    step();
    blk_valid = 1'b0;
    step();
    ready = 1'b0;
    held  = ifa.data;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_valid", ifa.valid, 1'b1);
      chk("bp_hold",  ifa.data,  held);
      chk("bp_rdy",   rdy_a,     1'b0);
    end
    ready = 1'b1;
    wait_done(20, "bp_done_timeout");
    step();

    // Zero-length job with a block on offer.
    nb = 16'd0; blk_valid = 1'b1; blk_data = rnd128(); start = 1'b1;
    step();
    start = 1'b0;
    chk("zero_done", done_a, 1'b1);
    chk("zero_busy", busy_a, 1'b1);
    chk("zero_rdy",  rdy_a,  1'b0);
    step();
    chk("zero_done_end", done_a, 1'b0);
    chk("zero_busy_end", busy_a, 1'b0);
    blk_valid = 1'b0;
    step();

    // Asynchronous abort during word2 of block 1 in a 4-block job.
    nb = 16'd4; start = 1'b1;
    step();
    start = 1'b0; blk_valid = 1'b1; blk_data = rnd128();
    for (int c = 0; c < 40; c++) begin
      step();
      if (blk_hs_last) blk_data = rnd128();
      if (m_words == 6) break;
    end
    chk("abort_reached_word6", m_words, 6);
    #2;
    rst = 1'b1;
    #1;
    chk_idle("abort");
    blk_valid = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();
    run_job(1, "after_abort_timeout");

    // Synchronous clear mid-job.
    nb = 16'd2; start = 1'b1;
    step();
    start = 1'b0; blk_valid = 1'b1; blk_data = rnd128();
    step();
    blk_valid = 1'b0;
    step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk_idle("clear_mid");
    step();

    // Randomized jobs against the model.
    for (int j = 0; j < 20; j++) begin
      run_job($urandom_range(1, 5), "rand_job_timeout");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
